// File: rtl/intr_stack_ctrl.sv
// Interrupt entry/exit sequencer for a return-address stack: arbitrates calls,
// returns and prioritised interrupts, and drives PC select and stack strobes.
module intr_stack_ctrl #(
    parameter logic [9:0] VEC_BASE        = 10'h3C0,
    parameter int         VEC_STRIDE_LOG2 = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_call,
    input  logic       i_ret,
    input  logic       i_reti,
    input  logic [3:0] i_irq,
    input  logic [3:0] i_ie,
    input  logic       i_stk_overflow,
    input  logic       i_stk_underflow,
    output logic       o_stk_push,
    output logic       o_stk_pop,
    output logic       o_stk_interrupt,
    output logic [1:0] o_pc_sel,
    output logic [9:0] o_vector,
    output logic [3:0] o_irq_ack,
    output logic       o_in_isr,
    output logic       o_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ENTRY = 2'd1,
        S_ISR   = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] PC_SEQ   = 2'b00;
    localparam logic [1:0] PC_VEC   = 2'b01;
    localparam logic [1:0] PC_STACK = 2'b10;
    localparam logic [1:0] PC_HOLD  = 2'b11;

    state_t     r_state;
    state_t     w_state_next;
    logic [1:0] r_irq_id;
    logic [1:0] w_irq_id_sel;
    logic [3:0] w_pending;
    logic [9:0] w_vec_offset;
    logic       w_stk_fault;

    assign w_pending    = i_irq & i_ie;
    assign w_stk_fault  = i_stk_overflow | i_stk_underflow;
    assign w_vec_offset = 10'(r_irq_id) << VEC_STRIDE_LOG2;

    // Lowest-numbered pending line wins; scanning downward lets bit 0 overwrite last.
    always_comb begin
        w_irq_id_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_pending[i]) begin
                w_irq_id_sel = 2'(i);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= S_IDLE;
            r_irq_id <= 2'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_state_next == S_ENTRY) begin
                r_irq_id <= w_irq_id_sel;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        o_stk_push      = 1'b0;
        o_stk_pop       = 1'b0;
        o_stk_interrupt = 1'b0;
        o_pc_sel        = PC_SEQ;
        o_vector        = VEC_BASE + w_vec_offset;
        o_irq_ack       = 4'b0000;
        o_in_isr        = 1'b0;
        o_fault         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (i_call) begin
                    o_stk_push = 1'b1;
                end else if (i_ret) begin
                    o_stk_pop = 1'b1;
                    o_pc_sel  = PC_STACK;
                end else if (w_pending != 4'b0000) begin
                    w_state_next = S_ENTRY;
                end
            end
            S_ENTRY: begin
                o_stk_push   = 1'b1;
                o_pc_sel     = PC_VEC;
                o_irq_ack    = 4'b0001 << r_irq_id;
                w_state_next = S_ISR;
            end
            S_ISR: begin
                o_in_isr = 1'b1;
                if (i_reti) begin
                    o_stk_pop       = 1'b1;
                    o_stk_interrupt = 1'b1;
                    o_pc_sel        = PC_STACK;
                    w_state_next    = S_IDLE;
                end else if (i_call) begin
                    o_stk_push = 1'b1;
                end else if (i_ret) begin
                    o_stk_pop = 1'b1;
                    o_pc_sel  = PC_STACK;
                end
            end
            default: begin
                o_fault  = 1'b1;
                o_pc_sel = PC_HOLD;
            end
        endcase

        if (r_state != S_FAULT && w_stk_fault) begin
            w_state_next = S_FAULT;
        end

        // Outputs are combinational, so hold them quiet while reset is asserted.
        if (!i_rst_n) begin
            o_stk_push      = 1'b0;
            o_stk_pop       = 1'b0;
            o_stk_interrupt = 1'b0;
            o_pc_sel        = PC_SEQ;
            o_vector        = VEC_BASE;
            o_irq_ack       = 4'b0000;
            o_in_isr        = 1'b0;
            o_fault         = 1'b0;
        end
    end

endmodule

// File: tb/tb_intr_stack_ctrl.sv
// Scoreboard bench for intr_stack_ctrl: a reference model queues the expected
// output bundle per cycle, which is popped and compared mid-cycle.
module tb_intr_stack_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       d_call, d_ret, d_reti, d_ovf, d_unf;
    logic [3:0] d_irq, d_ie;

    logic       o_push, o_pop, o_sint, o_in_isr, o_fault;
    logic [1:0] o_pc_sel;
    logic [9:0] o_vector;
    logic [3:0] o_ack;

    int n_tests = 0;
    int n_fail  = 0;

    logic [20:0] sb_q[$];
    logic [20:0] obs;

    // Bundle layout: push, pop, stk_interrupt, pc_sel, vector, irq_ack, in_isr, fault
    localparam logic [20:0] RESET_BUNDLE = {1'b0, 1'b0, 1'b0, 2'b00, 10'h3C0, 4'h0, 1'b0, 1'b0};

    int         m_state;
    logic [1:0] m_id;

    logic [9:0] l_vec;
    logic [3:0] l_ack;
    logic [1:0] l_pc;
    logic       l_push, l_pop, l_sint, l_isr, l_fault;

    always #5 clk = ~clk;

    intr_stack_ctrl dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_call          (d_call),
        .i_ret           (d_ret),
        .i_reti          (d_reti),
        .i_irq           (d_irq),
        .i_ie            (d_ie),
        .i_stk_overflow  (d_ovf),
        .i_stk_underflow (d_unf),
        .o_stk_push      (o_push),
        .o_stk_pop       (o_pop),
        .o_stk_interrupt (o_sint),
        .o_pc_sel        (o_pc_sel),
        .o_vector        (o_vector),
        .o_irq_ack       (o_ack),
        .o_in_isr        (o_in_isr),
        .o_fault         (o_fault)
    );

    assign obs = {o_push, o_pop, o_sint, o_pc_sel, o_vector, o_ack, o_in_isr, o_fault};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Model states: 0 idle, 1 entry, 2 isr, 3 fault
    function automatic logic [20:0] model_out();
        logic push, pop, sint, isr, flt;
        logic [1:0] pc;
        logic [3:0] ack;
        logic [9:0] vec;
        push = 0; pop = 0; sint = 0; isr = 0; flt = 0; pc = 2'b00; ack = 4'h0;
        vec = 10'h3C0 + 10'(m_id * 4);
        if (!rst_n) return RESET_BUNDLE;
        if (m_state == 0) begin
            if (d_call) push = 1;
            else if (d_ret) begin pop = 1; pc = 2'b10; end
        end else if (m_state == 1) begin
            push = 1; pc = 2'b01;
            ack[m_id] = 1'b1;
        end else if (m_state == 2) begin
            isr = 1;
            if (d_reti) begin pop = 1; sint = 1; pc = 2'b10; end
            else if (d_call) push = 1;
            else if (d_ret) begin pop = 1; pc = 2'b10; end
        end else begin
            flt = 1; pc = 2'b11;
        end
        return {push, pop, sint, pc, vec, ack, isr, flt};
    endfunction

    function automatic void model_step();
        logic [3:0] p;
        p = d_irq & d_ie;
        if (m_state != 3 && (d_ovf || d_unf)) begin
            m_state = 3;
        end else if (m_state == 0) begin
            if (!d_call && !d_ret && p != 4'h0) begin
                m_state = 1;
                if (p[0]) m_id = 2'd0;
                else if (p[1]) m_id = 2'd1;
                else if (p[2]) m_id = 2'd2;
                else m_id = 2'd3;
            end
        end else if (m_state == 1) begin
            m_state = 2;
        end else if (m_state == 2) begin
            if (d_reti) m_state = 0;
        end
    endfunction

    // One clock cycle: drive, queue expectation, compare at negedge, advance model at posedge.
    task automatic cycle(input string tag, input logic c, input logic r, input logic rt,
                         input logic [3:0] irq, input logic [3:0] ie,
                         input logic ov, input logic un);
        logic [20:0] exp;
        d_call = c; d_ret = r; d_reti = rt; d_irq = irq; d_ie = ie; d_ovf = ov; d_unf = un;
        sb_q.push_back(model_out());
        @(negedge clk);
        exp = sb_q.pop_front();
        l_vec = o_vector; l_ack = o_ack; l_pc = o_pc_sel; l_push = o_push; l_pop = o_pop;
        l_sint = o_sint; l_isr = o_in_isr; l_fault = o_fault;
        check_val(tag, 32'(obs), 32'(exp));
        $display("[TB] %-10s c=%b r=%b rt=%b irq=%h ie=%h ov=%b un=%b -> bundle=%h", tag, c, r, rt,
                 irq, ie, ov, un, obs);
        @(posedge clk);
        model_step();
        #1;
    endtask

    // Asserts reset between edges with busy inputs, checks the immediate effect, releases after an edge.
    task automatic do_reset(input string tag);
        d_call = 1; d_ret = 0; d_reti = 1; d_irq = 4'hF; d_ie = 4'hF; d_ovf = 0; d_unf = 0;
        rst_n = 1'b0;
        m_state = 0;
        m_id = 2'd0;
        #2;
        check_val(tag, 32'(obs), 32'(RESET_BUNDLE));
        $display("[TB] %-10s reset asserted -> bundle=%h", tag, obs);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        d_call = 0; d_ret = 0; d_reti = 0; d_irq = 4'h0; d_ie = 4'h0; d_ovf = 0; d_unf = 0;
        m_state = 0; m_id = 2'd0;
        #3;
        check_val("rst_init", 32'(obs), 32'(RESET_BUNDLE));
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Priority pick of line 1 from 0110, vector 3C4
        cycle("r033_idle", 0, 0, 0, 4'b0110, 4'hF, 0, 0);
        cycle("r033_entry", 0, 0, 0, 4'b0000, 4'hF, 0, 0);
        check_val("r033_vec", 32'(l_vec), 32'h3C4);
        check_val("r033_ack", 32'(l_ack), 32'b0010);
        check_val("r033_push", 32'(l_push), 32'd1);
        check_val("r033_pc", 32'(l_pc), 32'b01);
        cycle("r033_isr", 0, 0, 0, 4'b0000, 4'hF, 0, 0);
        check_val("r033_inisr", 32'(l_isr), 32'd1);

        // Nested call/ret inside handler then reti
        cycle("r035_call", 1, 1, 0, 4'h0, 4'hF, 0, 0);
        check_val("r035_push", 32'(l_push), 32'd1);
        cycle("r035_ret", 0, 1, 0, 4'h0, 4'hF, 0, 0);
        check_val("r035_retsi", 32'({l_pop, l_sint}), 32'b10);
        cycle("r035_reti", 1, 1, 1, 4'h0, 4'hF, 0, 0);
        check_val("r035_retisi", 32'({l_pop, l_sint, l_pc}), 32'b1110);
        cycle("r035_after", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        check_val("r035_inisr0", 32'(l_isr), 32'd0);

        // Call defers interrupt recognition by one cycle
        cycle("r034_call", 1, 0, 0, 4'b0001, 4'hF, 0, 0);
        check_val("r034_ack0", 32'(l_ack), 32'd0);
        cycle("r034_idle", 0, 0, 0, 4'b0001, 4'hF, 0, 0);
        cycle("r034_entry", 0, 0, 0, 4'b0001, 4'hF, 0, 0);
        check_val("r034_vec", 32'(l_vec), 32'h3C0);

        // No nesting while in handler; re-entry right after reti
        for (int i = 0; i < 4; i++) cycle("r036_isr", 0, 0, 0, 4'hF, 4'hF, 0, 0);
        check_val("r036_noack", 32'(l_ack), 32'd0);
        cycle("r036_reti", 0, 0, 1, 4'hF, 4'hF, 0, 0);
        cycle("r036_idle", 0, 0, 0, 4'hF, 4'hF, 0, 0);
        cycle("r036_entry", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        check_val("r036_ack", 32'(l_ack), 32'b0001);
        cycle("r036_isr2", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        cycle("r036_reti2", 0, 0, 1, 4'h0, 4'hF, 0, 0);

        // reti in idle and masked requests are ignored
        cycle("r038_reti", 0, 0, 1, 4'h0, 4'hF, 0, 0);
        for (int i = 0; i < 3; i++) cycle("r038_mask", 0, 0, 0, 4'hF, 4'h0, 0, 0);
        check_val("r038_state", 32'({l_isr, l_push, l_pop, l_ack}), 32'd0);

        // Reset in the middle of the entry cycle
        cycle("r032_idle", 0, 0, 0, 4'b1000, 4'hF, 0, 0);
        do_reset("r032_rst");
        cycle("r032_after", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        check_val("r032_ack", 32'(l_ack), 32'd0);

        // Random traffic without stack faults
        for (int i = 0; i < 300; i++) begin
            cycle("rand", 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 2) == 0), 4'($urandom), 4'($urandom), 0, 0);
        end
        do_reset("rand_rst");

        // Overflow in handler latches fault until reset
        cycle("r037_idle", 0, 0, 0, 4'b0100, 4'hF, 0, 0);
        cycle("r037_entry", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        cycle("r037_ovf", 0, 0, 0, 4'h0, 4'hF, 1, 0);
        for (int i = 0; i < 6; i++) begin
            cycle("r037_hold", 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                  1'($urandom), 1'($urandom));
        end
        check_val("r037_fault", 32'({l_fault, l_pc, l_push, l_pop, l_ack, l_isr}), 32'b1_11_0_0_0000_0);
        do_reset("r037_rst");
        cycle("r037_after", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        check_val("r037_clear", 32'(l_fault), 32'd0);

        // Underflow from idle, with a call in the same cycle
        cycle("unf_idle", 1, 0, 0, 4'h0, 4'hF, 0, 1);
        cycle("unf_fault", 0, 0, 0, 4'h0, 4'hF, 0, 0);
        check_val("unf_fault", 32'(l_fault), 32'd1);
        do_reset("unf_rst");
        cycle("end_idle", 0, 0, 0, 4'h0, 4'h0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/intr_stack_ctrl.md
INTR_STACK_CTRL -- requirements
Module: intr_stack_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 10'h3C0, base of the interrupt vector table in instruction memory.
REQ-002 Parameter VEC_STRIDE_LOG2, default 2, log2 spacing in words between consecutive vectors.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset; low forces reset state immediately, independent of clk.
REQ-005 call  in  1  decoder: current instruction is a subroutine call.
REQ-006 ret  in  1  decoder: current instruction is a subroutine return.
REQ-007 reti  in  1  decoder: current instruction is an interrupt return.
REQ-008 irq  in  4  level-sensitive interrupt requests; bit 0 highest priority.
REQ-009 ie  in  4  per-line interrupt enable.
REQ-010 stk_overflow, stk_underflow  in  1 each  status flags from the return-address stack.
REQ-011 stk_push, stk_pop  out  1 each  stack push/pop strobes.
REQ-012 stk_interrupt  out  1  selects stack output = stored address (1) or stored address + 1 (0).
REQ-013 pc_sel  out  2  00 sequential/decoder, 01 vector, 10 stack output, 11 hold (PC frozen).
REQ-014 vector  out  10  VEC_BASE + (irq_id << VEC_STRIDE_LOG2); valid when pc_sel = 01.
REQ-015 irq_ack  out  4  one-hot acknowledge of the accepted line, one cycle.
REQ-016 in_isr  out  1  high while an interrupt handler is executing.
REQ-017 fault  out  1  sticky stack-fault indicator.

Function
REQ-018 FSM states IDLE, ENTRY, ISR, FAULT; outputs are combinational from state and inputs; state, irq_id registered.
REQ-019 pending = irq & ie; irq_id = index of lowest set bit of pending, latched on IDLE->ENTRY transition.
REQ-020 IDLE/ISR, call=1: stk_push=1, pc_sel=00; call and ret both high -> call wins, ret ignored.
REQ-021 IDLE/ISR, ret=1 (call=0): stk_pop=1, stk_interrupt=0, pc_sel=10 in the same cycle.
REQ-022 IDLE, pending!=0, call=0, ret=0: next state ENTRY; interrupt recognition deferred one cycle if call or ret is high.
REQ-023 IDLE, reti=1: ignored, no strobes, no state change.
REQ-024 ENTRY (exactly one cycle): stk_push=1, stk_interrupt=0, pc_sel=01, vector valid, irq_ack[irq_id]=1; call/ret/reti ignored; next ISR.
REQ-025 ISR: in_isr=1; irq ignored (no nesting); call/ret handled per REQ-020/021.
REQ-026 ISR, reti=1: stk_pop=1, stk_interrupt=1, pc_sel=10 same cycle, next IDLE; reti wins over call/ret in that cycle.
REQ-027 Any state except FAULT, stk_overflow or stk_underflow sampled high at a clk edge: next FAULT.
REQ-028 FAULT: fault=1, pc_sel=11, all strobes and irq_ack 0, in_isr 0; exit only by reset.
REQ-029 At most one of stk_push/stk_pop high in any cycle.
REQ-030 Vector computation truncates to 10 bits; no carry beyond bit 9.

Reset
REQ-031 reset low: state IDLE, irq_id 0, stk_push=0, stk_pop=0, stk_interrupt=0, pc_sel=00, vector=VEC_BASE, irq_ack=0, in_isr=0, fault=0.
REQ-032 reset asserted mid-ENTRY or mid-ISR aborts the sequence; first cycle after release is IDLE with no pending acknowledge carried over.

Verification
REQ-033 ie=4'hF, irq=4'b0110 in IDLE -> next cycle ENTRY: stk_push=1, pc_sel=01, vector=10'h3C4, irq_ack=4'b0010; then in_isr=1.
REQ-034 irq=4'b0001 with call=1 same cycle -> stk_push for call only; ENTRY one cycle later with vector=10'h3C0.
REQ-035 In ISR, call then ret then reti -> push; pop with stk_interrupt=0; pop with stk_interrupt=1, pc_sel=10; state IDLE, in_isr=0.
REQ-036 In ISR, irq=4'hF held -> no irq_ack until after reti; IDLE then ENTRY on following cycle.
REQ-037 stk_overflow=1 for one cycle in ISR -> fault=1, pc_sel=11, held with inputs toggling until reset low, then all outputs per REQ-031.
REQ-038 reti=1 in IDLE, and ie=0 with irq=4'hF -> no strobes, no irq_ack, state remains IDLE.
